// File: rtl/operand_stack.sv
// Operand stack feeding a two-input ALU: registered top/second outputs, ALU writeback paths.
// Define OPERAND_STACK_GUARD_EN to latch sticky ovf/udf on suppressed commands.
module operand_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 cmd,
    input  logic [WIDTH-1:0]           push_data,
    input  logic [WIDTH-1:0]           wb0,
    input  logic [WIDTH-1:0]           wb1,
    output logic [WIDTH-1:0]           stack0,
    output logic [WIDTH-1:0]           stack1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] CMD_PUSH   = 3'b001;
    localparam logic [2:0] CMD_POP    = 3'b010;
    localparam logic [2:0] CMD_WB2    = 3'b011;
    localparam logic [2:0] CMD_REDUCE = 3'b100;
    localparam logic [2:0] CMD_DUP    = 3'b101;
    localparam logic [2:0] CMD_SWAP   = 3'b110;
    localparam logic [2:0] CMD_CLEAR  = 3'b111;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    logic             is_full, lt1, lt2;
    logic [AW-1:0]    top_idx, sec_idx, thr_idx;
    logic [WIDTH-1:0] third;

    // wp_q is the next free slot; indices wrap naturally in AW bits
    assign top_idx = wp_q - AW'(1);
    assign sec_idx = wp_q - AW'(2);
    assign thr_idx = wp_q - AW'(3);
    assign is_full = (cnt_q == CW'(DEPTH));
    assign lt1     = (cnt_q < CW'(1));
    assign lt2     = (cnt_q < CW'(2));
    assign third   = (cnt_q >= CW'(3)) ? mem_q[thr_idx] : '0;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        s0_d  = s0_q;
        s1_d  = s1_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        // unknown cmd falls into default and behaves as NOP
        case (cmd)
            CMD_PUSH: begin
                if (is_full) begin
`ifdef OPERAND_STACK_GUARD_EN
                    ovf_d = 1'b1;
`endif
                end else begin
                    mem_d[wp_q] = push_data;
                    wp_d  = wp_q + AW'(1);
                    cnt_d = cnt_q + CW'(1);
                    s0_d  = push_data;
                    s1_d  = s0_q;
                end
            end
            CMD_DUP: begin
                if (is_full) begin
`ifdef OPERAND_STACK_GUARD_EN
                    ovf_d = 1'b1;
`endif
                end else if (lt1) begin
`ifdef OPERAND_STACK_GUARD_EN
                    udf_d = 1'b1;
`endif
                end else begin
                    mem_d[wp_q] = s0_q;
                    wp_d  = wp_q + AW'(1);
                    cnt_d = cnt_q + CW'(1);
                    s1_d  = s0_q;
                end
            end
            CMD_POP: begin
                if (lt1) begin
`ifdef OPERAND_STACK_GUARD_EN
                    udf_d = 1'b1;
`endif
                end else begin
                    wp_d  = wp_q - AW'(1);
                    cnt_d = cnt_q - CW'(1);
                    s0_d  = s1_q;
                    s1_d  = third;
                end
            end
            CMD_WB2: begin
                if (lt2) begin
`ifdef OPERAND_STACK_GUARD_EN
                    udf_d = 1'b1;
`endif
                end else begin
                    mem_d[top_idx] = wb0;
                    mem_d[sec_idx] = wb1;
                    s0_d = wb0;
                    s1_d = wb1;
                end
            end
            CMD_REDUCE: begin
                if (lt2) begin
`ifdef OPERAND_STACK_GUARD_EN
                    udf_d = 1'b1;
`endif
                end else begin
                    mem_d[sec_idx] = wb0;
                    wp_d  = wp_q - AW'(1);
                    cnt_d = cnt_q - CW'(1);
                    s0_d  = wb0;
                    s1_d  = third;
                end
            end
            CMD_SWAP: begin
                if (lt2) begin
`ifdef OPERAND_STACK_GUARD_EN
                    udf_d = 1'b1;
`endif
                end else begin
                    mem_d[top_idx] = s1_q;
                    mem_d[sec_idx] = s0_q;
                    s0_d = s1_q;
                    s1_d = s0_q;
                end
            end
            CMD_CLEAR: begin
                wp_d  = '0;
                cnt_d = '0;
                s0_d  = '0;
                s1_d  = '0;
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            s0_q  <= '0;
            s1_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign stack0 = s0_q;
    assign stack1 = s1_q;
    assign count  = cnt_q;
    assign full   = is_full;
    assign empty  = (cnt_q == '0);
    assign ovf    = ovf_q;
    assign udf    = udf_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: hand-computed vectors, immediate assertions.
module tb_operand_stack;
    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, WB2 = 3'b011,
                           REDUCE = 3'b100, DUP = 3'b101, SWAP = 3'b110, CLEAR = 3'b111;
`ifdef OPERAND_STACK_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    logic       clk, rst_n;
    logic [2:0] cmd;
    logic [7:0] push_data, wb0, wb1, stack0, stack1;
    logic [3:0] count;
    logic       full, empty, ovf, udf;
    int total = 0;
    int bad = 0;

    operand_stack #(.DEPTH(8), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .push_data(push_data),
        .wb0(wb0), .wb1(wb1), .stack0(stack0), .stack1(stack1),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] c, input logic [7:0] d, input logic [7:0] a,
                        input logic [7:0] b);
        cmd = c; push_data = d; wb0 = a; wb1 = b;
        @(posedge clk);
        #1;
        cmd = NOP;
    endtask

    initial begin
        rst_n = 1'b0; cmd = NOP; push_data = '0; wb0 = '0; wb1 = '0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_s0", stack0, 0);
        chk("rst_s1", stack1, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // push/push/reduce
        step(PUSH, 8'd34, 0, 0);
        step(PUSH, 8'd76, 0, 0);
        chk("push2_s0", stack0, 76);
        chk("push2_s1", stack1, 34);
        chk("push2_cnt", count, 2);
        step(REDUCE, 0, 8'd110, 0);
        chk("red_s0", stack0, 110);
        chk("red_s1", stack1, 0);
        chk("red_cnt", count, 1);

        // swap and writeback
        step(CLEAR, 0, 0, 0);
        step(PUSH, 8'd30, 0, 0);
        step(PUSH, 8'd50, 0, 0);
        step(SWAP, 0, 0, 0);
        chk("swap_s0", stack0, 30);
        chk("swap_s1", stack1, 50);
        step(WB2, 0, 8'hE3, 8'hAA);
        chk("wb2_s0", stack0, 8'hE3);
        chk("wb2_s1", stack1, 8'hAA);
        chk("wb2_cnt", count, 2);
        step(POP, 0, 0, 0);
        chk("pop_s0", stack0, 8'hAA);
        chk("pop_s1", stack1, 0);
        chk("pop_cnt", count, 1);
        step(SWAP, 0, 0, 0);
        chk("swap1_cnt", count, 1);
        chk("swap1_s0", stack0, 8'hAA);
        chk("swap1_udf", udf, GUARD);

        // pop exposes third entry
        step(CLEAR, 0, 0, 0);
        chk("clr_udf", udf, 0);
        step(PUSH, 8'd1, 0, 0);
        step(PUSH, 8'd2, 0, 0);
        step(PUSH, 8'd3, 0, 0);
        step(POP, 0, 0, 0);
        chk("pop3_s0", stack0, 2);
        chk("pop3_s1", stack1, 1);

        // fill and overflow
        step(CLEAR, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(PUSH, 8'(i), 0, 0);
        chk("fill_full", full, 1);
        chk("fill_s1", stack1, 7);
        step(PUSH, 8'd9, 0, 0);
        chk("ovf_full", full, 1);
        chk("ovf_cnt", count, 8);
        chk("ovf_s0", stack0, 8);
        chk("ovf_flag", ovf, GUARD);
        step(DUP, 0, 0, 0);
        chk("dupfull_cnt", count, 8);
        step(POP, 0, 0, 0);
        chk("popfull_s0", stack0, 7);
        chk("popfull_s1", stack1, 6);
        chk("popfull_cnt", count, 7);
        chk("popfull_ovf", ovf, GUARD);
        step(PUSH, 8'd9, 0, 0);
        chk("refill_s0", stack0, 9);
        chk("refill_s1", stack1, 7);
        step(CLEAR, 0, 0, 0);
        chk("clr_cnt", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_ovf", ovf, 0);
        chk("clr_s0", stack0, 0);

        // underflow and dup
        step(POP, 0, 0, 0);
        chk("udf_cnt", count, 0);
        chk("udf_s0", stack0, 0);
        chk("udf_flag", udf, GUARD);
        step(PUSH, 8'd5, 0, 0);
        step(DUP, 0, 0, 0);
        chk("dup_s0", stack0, 5);
        chk("dup_s1", stack1, 5);
        chk("dup_cnt", count, 2);
        chk("dup_udf", udf, GUARD);
        step(3'bxxx, 8'd99, 8'd98, 8'd97);
        chk("xcmd_cnt", count, 2);
        chk("xcmd_s0", stack0, 5);

        // reset mid-operation
        step(CLEAR, 0, 0, 0);
        step(PUSH, 8'd11, 0, 0);
        step(PUSH, 8'd12, 0, 0);
        step(PUSH, 8'd13, 0, 0);
        cmd = PUSH; push_data = 8'd44;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_cnt", count, 0);
        chk("mrst_s0", stack0, 0);
        chk("mrst_s1", stack1, 0);
        chk("mrst_empty", empty, 1);
        @(posedge clk); #1;
        chk("mrst_hold", count, 0);
        rst_n = 1'b1;
        step(PUSH, 8'd7, 0, 0);
        chk("post_s0", stack0, 7);
        chk("post_cnt", count, 1);
        chk("post_s1", stack1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
